memory_bus_arbiter: RTL and testbench

- Shares the single memory_controller bus (addr/wdata/rdata/abort/write/size/prot/trans) between the instruction fetch port and the data access port of the processor.
- Grants one access at a time under round-robin priority and drives the bus with registered outputs.
- Waits a fixed memory latency, then returns rdata/abort with a one-cycle ack to the owning requester.
- Sits between processor and memory_controller; replaces the processor's direct drive of the bus.

---
 rtl/memory_bus_arbiter_pkg.sv | 20 ++
 rtl/memory_bus_arbiter_rr_arbiter2.sv | 44 ++++
 rtl/memory_bus_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_bus_arbiter_pkg.sv
// Shared encodings for the memory bus arbiter: FSM states, bus transfer types and owner ids.
package memory_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  localparam logic [1:0] TRANS_IDLE = 2'b00;
  localparam logic [1:0] TRANS_NSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ  = 2'b11;

endpackage

// File: rtl/memory_bus_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter; on contention the port that did not win the previous grant wins.
module rr_arbiter2
  import memory_bus_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   n_reset,
  input  logic   en_i,
  input  logic   req_instr_i,
  input  logic   req_data_i,
  output logic   gnt_valid_o,
  output owner_e gnt_owner_o
);

  owner_e last_owner_q, last_owner_d;

  // Grant selection and last-owner bookkeeping
  always_comb begin
    gnt_valid_o  = en_i & (req_instr_i | req_data_i);
    gnt_owner_o  = OWNER_INSTR;
    last_owner_d = last_owner_q;
    if (req_instr_i && req_data_i) begin
      gnt_owner_o = (last_owner_q == OWNER_DATA) ? OWNER_INSTR : OWNER_DATA;
    end else if (req_data_i) begin
      gnt_owner_o = OWNER_DATA;
    end else begin
      gnt_owner_o = OWNER_INSTR;
    end
    if (gnt_valid_o) begin
      last_owner_d = gnt_owner_o;
    end else begin
      last_owner_d = last_owner_q;
    end
  end

  // Reset to DATA so the first contended grant goes to fetch
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      last_owner_q <= OWNER_DATA;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Shares the memory_controller bus between fetch and data ports: one access at a time,
// registered bus drive, fixed-latency response returned to the owner with a one-cycle ack.
module memory_bus_arbiter
  import memory_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_prot,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_abort,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_write,
  input  logic              d_size,
  input  logic [1:0]        d_prot,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_abort,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_abort,
  output logic              mem_write,
  output logic              mem_size,
  output logic [1:0]        mem_prot,
  output logic [1:0]        mem_trans
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              prev_valid_q, prev_valid_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_size_q, mem_size_d;
  logic [1:0]        mem_prot_q, mem_prot_d;
  logic [1:0]        mem_trans_q, mem_trans_d;
  logic              i_ack_q, i_ack_d, i_abort_q, i_abort_d;
  logic              d_ack_q, d_ack_d, d_abort_q, d_abort_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  logic              in_resp_s, grant_en_s, gnt_valid_s;
  owner_e            gnt_owner_s;
  logic [ADDR_W-1:0] gnt_addr_s;

  assign in_resp_s  = (state_q == ST_RESP);
  assign grant_en_s = (state_q == ST_IDLE) || in_resp_s;

  // The owner's request is still high during its own ack cycle and must not be re-granted
  rr_arbiter2 u_rr (
    .clk         (clk),
    .n_reset     (n_reset),
    .en_i        (grant_en_s),
    .req_instr_i (i_req & ~(in_resp_s & (owner_q == OWNER_INSTR))),
    .req_data_i  (d_req & ~(in_resp_s & (owner_q == OWNER_DATA))),
    .gnt_valid_o (gnt_valid_s),
    .gnt_owner_o (gnt_owner_s)
  );

  assign gnt_addr_s = (gnt_owner_s == OWNER_DATA) ? d_addr : i_addr;

  // Next-state and next-output logic; addr/wdata/size/prot hold between accesses
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    prev_valid_d = prev_valid_q;
    wr_d         = wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_write_d  = 1'b0;
    mem_size_d   = mem_size_q;
    mem_prot_d   = mem_prot_q;
    mem_trans_d  = TRANS_IDLE;
    i_ack_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    i_abort_d    = i_abort_q;
    d_ack_d      = 1'b0;
    d_rdata_d    = d_rdata_q;
    d_abort_d    = d_abort_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (gnt_valid_s) begin
          state_d      = ST_ADDR;
          owner_d      = gnt_owner_s;
          prev_valid_d = 1'b1;
          mem_addr_d   = gnt_addr_s;
          // mem_addr_q / owner_q still describe the previous access here
          if (prev_valid_q && (owner_q == gnt_owner_s) &&
              (gnt_addr_s == mem_addr_q + ADDR_W'(1))) begin
            mem_trans_d = TRANS_SEQ;
          end else begin
            mem_trans_d = TRANS_NSEQ;
          end
          if (gnt_owner_s == OWNER_DATA) begin
            mem_wdata_d = d_wdata;
            mem_write_d = d_write;
            mem_size_d  = d_size;
            mem_prot_d  = d_prot;
            wr_d        = d_write;
          end else begin
            mem_wdata_d = mem_wdata_q;
            mem_write_d = 1'b0;
            mem_size_d  = 1'b1;
            mem_prot_d  = i_prot;
            wr_d        = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_RESP;
          if (mem_abort) begin
            prev_valid_d = 1'b0;
          end else begin
            prev_valid_d = prev_valid_q;
          end
          if (owner_q == OWNER_INSTR) begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata;
            i_abort_d = mem_abort;
          end else begin
            d_ack_d   = 1'b1;
            d_abort_d = mem_abort;
            if (!wr_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_DATA;
      cnt_q        <= {CNT_W{1'b0}};
      prev_valid_q <= 1'b0;
      wr_q         <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      mem_write_q  <= 1'b0;
      mem_size_q   <= 1'b0;
      mem_prot_q   <= 2'b00;
      mem_trans_q  <= TRANS_IDLE;
      i_ack_q      <= 1'b0;
      i_rdata_q    <= {DATA_W{1'b0}};
      i_abort_q    <= 1'b0;
      d_ack_q      <= 1'b0;
      d_rdata_q    <= {DATA_W{1'b0}};
      d_abort_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      prev_valid_q <= prev_valid_d;
      wr_q         <= wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_write_q  <= mem_write_d;
      mem_size_q   <= mem_size_d;
      mem_prot_q   <= mem_prot_d;
      mem_trans_q  <= mem_trans_d;
      i_ack_q      <= i_ack_d;
      i_rdata_q    <= i_rdata_d;
      i_abort_q    <= i_abort_d;
      d_ack_q      <= d_ack_d;
      d_rdata_q    <= d_rdata_d;
      d_abort_q    <= d_abort_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_write = mem_write_q;
  assign mem_size  = mem_size_q;
  assign mem_prot  = mem_prot_q;
  assign mem_trans = mem_trans_q;
  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign i_abort   = i_abort_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_abort   = d_abort_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: cycle-timed transaction model checked every cycle (LATENCY=1)
// plus directed literal checks, and a LATENCY=3 instance for the mid-access reset case.
module tb_memory_bus_arbiter;

  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // LATENCY=1 instance signals
  logic n_reset, i_req, i_ack, i_abort, d_req, d_write, d_size, d_ack, d_abort;
  logic mem_abort, mem_write, mem_size;
  logic [1:0] i_prot, d_prot, mem_prot, mem_trans;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  // LATENCY=3 instance signals
  logic n_reset3, i_req3, i_ack3, i_abort3, d_req3, d_write3, d_size3, d_ack3, d_abort3;
  logic mem_abort3, mem_write3, mem_size3;
  logic [1:0] i_prot3, d_prot3, mem_prot3, mem_trans3;
  logic [31:0] i_addr3, i_rdata3, d_addr3, d_wdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  memory_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT1)) u_dut (
    .clk(clk), .n_reset(n_reset),
    .i_req(i_req), .i_addr(i_addr), .i_prot(i_prot), .i_ack(i_ack), .i_rdata(i_rdata), .i_abort(i_abort),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_write(d_write), .d_size(d_size), .d_prot(d_prot),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_abort(d_abort),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_abort(mem_abort),
    .mem_write(mem_write), .mem_size(mem_size), .mem_prot(mem_prot), .mem_trans(mem_trans));

  memory_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT3)) u_dut3 (
    .clk(clk), .n_reset(n_reset3),
    .i_req(i_req3), .i_addr(i_addr3), .i_prot(i_prot3), .i_ack(i_ack3), .i_rdata(i_rdata3), .i_abort(i_abort3),
    .d_req(d_req3), .d_addr(d_addr3), .d_wdata(d_wdata3), .d_write(d_write3), .d_size(d_size3), .d_prot(d_prot3),
    .d_ack(d_ack3), .d_rdata(d_rdata3), .d_abort(d_abort3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .mem_abort(mem_abort3),
    .mem_write(mem_write3), .mem_size(mem_size3), .mem_prot(mem_prot3), .mem_trans(mem_trans3));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
  endfunction

  // ---------------- memory responders ----------------
  logic [31:0] resp_mem [logic [31:0]];
  logic        abort_en = 1'b0;
  logic [31:0] abort_addr = 32'h0;
  bit          r_pend, r3_pend;
  logic [31:0] r_addr, r3_addr;
  int          r_el, r3_el;

  function automatic logic [31:0] resp_read(input logic [31:0] a);
    return resp_mem.exists(a) ? resp_mem[a] : init_word(a);
  endfunction

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_pend = 1'b0;
    else if (mem_trans != 2'b00) begin
      r_pend = 1'b1; r_addr = mem_addr; r_el = 0;
      if (mem_write) resp_mem[mem_addr] = mem_wdata;
    end
  end

  // Data is only valid in the one cycle LATENCY after the address phase; garbage otherwise
  always @(negedge clk) begin
    if (r_pend) r_el++;
    if (r_pend && r_el == LAT1) begin
      mem_rdata = resp_read(r_addr);
      mem_abort = abort_en && (r_addr == abort_addr);
    end else begin
      mem_rdata = 32'hBAD0_BAD0;
      mem_abort = 1'b1;
    end
  end

  always @(posedge clk or negedge n_reset3) begin
    if (!n_reset3) r3_pend = 1'b0;
    else if (mem_trans3 != 2'b00) begin
      r3_pend = 1'b1; r3_addr = mem_addr3; r3_el = 0;
    end
  end

  always @(negedge clk) begin
    if (r3_pend) r3_el++;
    if (r3_pend && r3_el == LAT3) begin
      mem_rdata3 = init_word(r3_addr);
      mem_abort3 = 1'b0;
    end else begin
      mem_rdata3 = 32'hBAD0_BAD0;
      mem_abort3 = 1'b1;
    end
  end

  // ---------------- transaction model (LATENCY=1 instance) ----------------
  logic [31:0] model_mem [logic [31:0]];
  int          t_cyc, g_cyc;
  bit          busy, own_d, last_d, pv, pown, pwr, in_resp, ri, rd, take_d, ab;
  logic [31:0] gaddr, paddr, na;
  logic [1:0]  exp_trans, exp_prot;
  logic [31:0] exp_addr, exp_wdata, exp_irdata, exp_drdata;
  logic        exp_write, exp_size, exp_iack, exp_iabort, exp_dack, exp_dabort;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      t_cyc = 0; busy = 1'b0; last_d = 1'b1; pv = 1'b0; own_d = 1'b0;
      exp_trans = 2'b00; exp_prot = 2'b00; exp_addr = 32'h0; exp_wdata = 32'h0;
      exp_irdata = 32'h0; exp_drdata = 32'h0; exp_write = 1'b0; exp_size = 1'b0;
      exp_iack = 1'b0; exp_iabort = 1'b0; exp_dack = 1'b0; exp_dabort = 1'b0;
    end else begin
      exp_trans = 2'b00; exp_write = 1'b0; exp_iack = 1'b0; exp_dack = 1'b0;
      in_resp = busy && (t_cyc == g_cyc + LAT1 + 1);
      if (busy && t_cyc == g_cyc + LAT1) begin
        ab = abort_en && (gaddr == abort_addr);
        if (!own_d) begin
          exp_iack = 1'b1; exp_irdata = model_read(gaddr); exp_iabort = ab;
        end else begin
          exp_dack = 1'b1; exp_dabort = ab;
          if (!pwr) exp_drdata = model_read(gaddr);
        end
        if (ab) pv = 1'b0;
      end
      if (in_resp) busy = 1'b0;
      if (!busy) begin
        ri = i_req && !(in_resp && !own_d);
        rd = d_req && !(in_resp && own_d);
        if (ri || rd) begin
          take_d = (ri && rd) ? !last_d : rd;
          na = take_d ? d_addr : i_addr;
          exp_trans = (pv && pown == take_d && na == paddr + 32'd1) ? 2'b11 : 2'b10;
          exp_addr = na;
          if (take_d) begin
            exp_wdata = d_wdata; exp_write = d_write; exp_size = d_size; exp_prot = d_prot;
            if (d_write) model_mem[d_addr] = d_wdata;
          end else begin
            exp_size = 1'b1; exp_prot = i_prot;
          end
          busy = 1'b1; g_cyc = t_cyc + 1; own_d = take_d; last_d = take_d;
          pv = 1'b1; paddr = na; pown = take_d; pwr = take_d && d_write; gaddr = na;
        end
      end
      t_cyc++;
    end
  end

  // Every-cycle comparison of the LATENCY=1 instance against the model
  always @(negedge clk) begin
    if (n_reset === 1'b1) begin
      check("mem_trans", mem_trans, exp_trans);
      check("mem_addr", mem_addr, exp_addr);
      check("mem_wdata", mem_wdata, exp_wdata);
      check("mem_write", mem_write, exp_write);
      check("mem_size", mem_size, exp_size);
      check("mem_prot", mem_prot, exp_prot);
      check("i_ack", i_ack, exp_iack);
      check("i_rdata", i_rdata, exp_irdata);
      check("i_abort", i_abort, exp_iabort);
      check("d_ack", d_ack, exp_dack);
      check("d_rdata", d_rdata, exp_drdata);
      check("d_abort", d_abort, exp_dabort);
    end
  end

  // Bus log of address phases for ordering / transfer-type literals
  logic [31:0] log_addr[$];
  logic [1:0]  log_trans[$];
  int          ack3_cnt = 0;
  always @(negedge clk) begin
    if (n_reset === 1'b1 && mem_trans != 2'b00) begin
      log_addr.push_back(mem_addr);
      log_trans.push_back(mem_trans);
    end
    if (i_ack3 === 1'b1 || d_ack3 === 1'b1) ack3_cnt++;
  end

  function automatic logic [31:0] log_a(input int idx);
    return (idx < log_addr.size()) ? log_addr[idx] : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [1:0] log_t(input int idx);
    return (idx < log_trans.size()) ? log_trans[idx] : 2'b01;
  endfunction

  // ---------------- stimulus ----------------
  task automatic wait_ack(input int sel, output int n);
    bit ok;
    n = 0; ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(posedge clk); #1; n++;
      if ((sel == 0 && i_ack) || (sel == 1 && d_ack) || (sel == 2 && i_ack3)) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL ack_timeout: port %0d got no ack within 40 cycles", sel);
    end
  endtask

  task automatic i_access(input logic [31:0] a, input bit keep, output int n,
                          output logic [31:0] rdat, output logic abt);
    i_addr = a; i_req = 1'b1;
    wait_ack(0, n);
    rdat = i_rdata; abt = i_abort;
    if (!keep) i_req = 1'b0;
  endtask

  task automatic d_access(input logic [31:0] a, input logic wr, input logic [31:0] wd, input bit keep,
                          output int n, output logic [31:0] rdat, output logic abt);
    d_addr = a; d_write = wr; d_wdata = wd; d_req = 1'b1;
    wait_ack(1, n);
    rdat = d_rdata; abt = d_abort;
    if (!keep) d_req = 1'b0;
  endtask

  task automatic reset1();
    i_req = 1'b0; d_req = 1'b0;
    n_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int n, n2, base;
    logic [31:0] rdat, rdat2;
    logic abt, abt2;
    n_reset = 1'b0; n_reset3 = 1'b0;
    i_req = 1'b0; i_addr = 32'h0; i_prot = 2'b01;
    d_req = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_write = 1'b0; d_size = 1'b1; d_prot = 2'b10;
    i_req3 = 1'b0; i_addr3 = 32'h0; i_prot3 = 2'b11;
    d_req3 = 1'b0; d_addr3 = 32'h0; d_wdata3 = 32'h0; d_write3 = 1'b0; d_size3 = 1'b0; d_prot3 = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_trans", mem_trans, 2'b00);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_size", mem_size, 1'b0);
    check("rst_acks", {i_ack, d_ack}, 2'b00);
    check("rst_rdata", {i_rdata, d_rdata}, 64'h0);
    n_reset = 1'b1; n_reset3 = 1'b1;
    @(posedge clk); #1;

    // Single fetch: ack LATENCY+2 edges after request
    base = log_addr.size();
    i_access(32'h10, 1'b0, n, rdat, abt);
    check("fetch_lat", n, LAT1 + 2);
    check("fetch_rdata", rdat, init_word(32'h10));
    check("fetch_trans", {log_t(base), log_a(base)}, {2'b10, 32'h10});

    // Sequential fetch with req held across the ack
    base = log_addr.size();
    i_access(32'h10, 1'b1, n, rdat, abt);
    i_access(32'h11, 1'b0, n2, rdat2, abt2);
    check("seq_trans0", log_t(base), 2'b10);
    check("seq_trans1", {log_t(base + 1), log_a(base + 1)}, {2'b11, 32'h11});
    check("seq_lat2", n2, LAT1 + 3);
    check("seq_rdata", rdat2, init_word(32'h11));

    // Contention right after reset: I, D, I, D
    reset1();
    base = log_addr.size();
    fork
      begin
        int ni; logic [31:0] ri_d; logic ri_a;
        i_access(32'h30, 1'b1, ni, ri_d, ri_a);
        i_access(32'h31, 1'b0, ni, ri_d, ri_a);
      end
      begin
        int nd; logic [31:0] rd_d; logic rd_a;
        d_access(32'h40, 1'b0, 32'h0, 1'b1, nd, rd_d, rd_a);
        d_access(32'h41, 1'b0, 32'h0, 1'b0, nd, rd_d, rd_a);
      end
    join
    check("rr_order", {log_a(base), log_a(base + 1), log_a(base + 2), log_a(base + 3)},
          {32'h30, 32'h40, 32'h31, 32'h41});
    check("rr_trans", {log_t(base), log_t(base + 1), log_t(base + 2), log_t(base + 3)}, 8'b10101010);

    // Write then read back
    @(posedge clk); #1;
    d_size = 1'b0;
    d_access(32'h20, 1'b1, 32'hDEAD_BEEF, 1'b0, n, rdat, abt);
    check("wr_keeps_rdata", rdat, init_word(32'h41));
    check("wr_lat", n, LAT1 + 2);
    d_size = 1'b1;
    @(posedge clk); #1;
    d_access(32'h20, 1'b0, 32'h0, 1'b0, n, rdat, abt);
    check("rd_after_wr", rdat, 32'hDEAD_BEEF);

    // Abort breaks the sequential chain
    abort_addr = 32'h50; abort_en = 1'b1;
    @(posedge clk); #1;
    d_access(32'h50, 1'b0, 32'h0, 1'b0, n, rdat, abt);
    abort_en = 1'b0;
    check("abort_flag", abt, 1'b1);
    check("abort_rdata", rdat, init_word(32'h50));
    base = log_addr.size();
    @(posedge clk); #1;
    d_access(32'h51, 1'b0, 32'h0, 1'b0, n, rdat, abt);
    check("post_abort_flag", abt, 1'b0);
    @(posedge clk); #1;
    d_access(32'h52, 1'b0, 32'h0, 1'b0, n, rdat, abt);
    check("post_abort_trans", {log_t(base), log_t(base + 1)}, 4'b1011);

    // Address wrap counts as sequential
    base = log_addr.size();
    i_prot = 2'b10;
    i_access(32'hFFFF_FFFF, 1'b0, n, rdat, abt);
    @(posedge clk); #1;
    i_access(32'h0000_0000, 1'b0, n, rdat, abt);
    check("wrap_trans", {log_t(base), log_t(base + 1)}, 4'b1011);
    check("wrap_rdata", rdat, init_word(32'h0));

    // LATENCY=3 instance: reset during WAIT drops the access
    @(posedge clk); #1;
    i_addr3 = 32'h10; i_req3 = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("l3_in_flight", mem_addr3, 32'h10);
    ack3_cnt = 0;
    n_reset3 = 1'b0;
    #1;
    check("l3_rst_trans", mem_trans3, 2'b00);
    check("l3_rst_addr", mem_addr3, 32'h0);
    check("l3_rst_attr", {mem_write3, mem_size3, mem_prot3}, 4'b0000);
    check("l3_rst_wdata", mem_wdata3, 32'h0);
    check("l3_rst_resp", {i_ack3, i_abort3, d_ack3, d_abort3}, 4'b0000);
    check("l3_rst_rdata", {i_rdata3, d_rdata3}, 64'h0);
    i_req3 = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_reset3 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("l3_no_ack", ack3_cnt, 0);
    i_addr3 = 32'h12; i_req3 = 1'b1;
    wait_ack(2, n);
    check("l3_lat", n, LAT3 + 2);
    check("l3_rdata", i_rdata3, init_word(32'h12));
    i_req3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
